// File: rtl/ex_mdu_ctrl.sv
// EX-stage sequencer for the shared iterative multiply/divide unit.
// Detects M-extension ops in EX, launches the MDU and stalls the pipeline
// until the result arrives. Division by zero and signed overflow are
// resolved locally without launching the unit. A watchdog bounds the BUSY
// time so a hung unit can never deadlock the pipeline.
module ex_mdu_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            E_valid,
  input  logic [6:0]      E_op,
  input  logic [2:0]      E_funct3,
  input  logic [6:0]      E_funct7,
  input  logic [XLEN-1:0] E_rs1,
  input  logic [XLEN-1:0] E_rs2,
  input  logic            E_flush,
  output logic            mdu_start,
  output logic            mdu_kill,
  output logic [2:0]      mdu_funct3,
  output logic [XLEN-1:0] mdu_a,
  output logic [XLEN-1:0] mdu_b,
  input  logic            mdu_done,
  input  logic [XLEN-1:0] mdu_result,
  output logic            E_mdu_stall,
  output logic            E_mdu_valid,
  output logic [XLEN-1:0] E_mdu_out,
  output logic            mdu_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             is_m;
  logic             div_zero;
  logic             div_ovf;

  // Result of an op resolved without the MDU: x/0 gives all-ones (quotient)
  // or the dividend (remainder); INT_MIN/-1 gives INT_MIN or 0.
  function automatic logic [XLEN-1:0] shortcut_result(input logic [2:0]      f3,
                                                      input logic [XLEN-1:0] rs1,
                                                      input logic            zero);
    logic [XLEN-1:0] r;
    if (zero) r = f3[1] ? rs1 : '1;
    else      r = f3[1] ? '0  : INT_MIN;
    return r;
  endfunction

  // Decode the EX instruction and its local-resolution cases.
  always_comb begin
    is_m     = E_valid && (E_op == 7'b0110011) && (E_funct7 == 7'b0000001);
    div_zero = E_funct3[2] && (E_rs2 == '0);
    div_ovf  = ((E_funct3 == 3'b100) || (E_funct3 == 3'b110)) &&
               (E_rs1 == INT_MIN) && (E_rs2 == '1);
  end

  // Stall and result-valid are combinational so EX sees them this cycle.
  always_comb begin
    E_mdu_stall = ((state == IDLE) && is_m && !E_flush) || (state == BUSY);
    E_mdu_valid = (state == DONE) && !E_flush;
  end

  // Sequencer: launch, wait for done/flush/watchdog, present result one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      mdu_start  <= 1'b0;
      mdu_kill   <= 1'b0;
      mdu_funct3 <= '0;
      mdu_a      <= '0;
      mdu_b      <= '0;
      E_mdu_out  <= '0;
      mdu_err    <= 1'b0;
    end else begin
      mdu_start <= 1'b0;
      mdu_kill  <= 1'b0;
      case (state)
        IDLE: begin
          if (is_m && !E_flush) begin
            if (div_zero || div_ovf) begin
              E_mdu_out <= shortcut_result(E_funct3, E_rs1, div_zero);
              state     <= DONE;
            end else begin
              mdu_start  <= 1'b1;
              mdu_funct3 <= E_funct3;
              mdu_a      <= E_rs1;
              mdu_b      <= E_rs2;
              count      <= '0;
              state      <= BUSY;
            end
          end
        end
        BUSY: begin
          count <= count + CNT_W'(1);
          if (E_flush) begin
            // Flush wins over a coincident done; the result is dropped.
            mdu_kill <= 1'b1;
            state    <= IDLE;
          end else if (mdu_done) begin
            E_mdu_out <= mdu_result;
            state     <= DONE;
          end else if (count == CNT_W'(TIMEOUT - 1)) begin
            // Hung unit: abort it and retire the op with a zero result.
            mdu_err   <= 1'b1;
            mdu_kill  <= 1'b1;
            E_mdu_out <= '0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Directed bench for ex_mdu_ctrl: a vector table of M ops with a behavioural
// MDU responder, plus hand-written flush, watchdog and reset sequences.
module tb_ex_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        E_valid;
  logic [6:0]  E_op;
  logic [2:0]  E_funct3;
  logic [6:0]  E_funct7;
  logic [31:0] E_rs1, E_rs2;
  logic        E_flush;
  logic        mdu_start, mdu_kill;
  logic [2:0]  mdu_funct3;
  logic [31:0] mdu_a, mdu_b;
  logic        mdu_done;
  logic [31:0] mdu_result;
  logic        E_mdu_stall, E_mdu_valid;
  logic [31:0] E_mdu_out;
  logic        mdu_err;

  ex_mdu_ctrl #(.XLEN(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .E_valid(E_valid), .E_op(E_op),
    .E_funct3(E_funct3), .E_funct7(E_funct7), .E_rs1(E_rs1), .E_rs2(E_rs2),
    .E_flush(E_flush), .mdu_start(mdu_start), .mdu_kill(mdu_kill),
    .mdu_funct3(mdu_funct3), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mdu_done(mdu_done), .mdu_result(mdu_result), .E_mdu_stall(E_mdu_stall),
    .E_mdu_valid(E_mdu_valid), .E_mdu_out(E_mdu_out), .mdu_err(mdu_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [31:0] res;       // value the model MDU returns
    int          lat;       // done in the lat-th BUSY cycle (start cycle = 1)
    int          exp_start;
    int          exp_stall;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[10];

  int n_checks = 0;
  int n_fail   = 0;

  int          r_stall, r_start, r_valid;
  logic [31:0] r_out;
  logic        r_kill, r_err, r_ab_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    E_valid  = 1'b1;
    E_op     = 7'b0110011;
    E_funct7 = 7'b0000001;
    E_funct3 = f3;
    E_rs1    = a;
    E_rs2    = b;
  endtask

  // Issue one M op and act as the MDU until E_mdu_valid (bounded).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat);
    int  s;
    bit  fin;
    s = -1; fin = 0;
    r_stall = 0; r_start = 0; r_valid = 0; r_out = '0;
    r_kill = 0; r_err = 0; r_ab_bad = 0;
    @(negedge clk);
    set_m(f3, a, b);
    mdu_result = res;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      mdu_done = 1'b0;
      #1;
      if (E_mdu_stall) r_stall++;
      if (mdu_start) begin
        r_start++;
        if (s < 0) s = c;
        if (mdu_a !== a || mdu_b !== b || mdu_funct3 !== f3) r_ab_bad = 1;
      end
      if (E_mdu_valid) begin
        r_valid++;
        r_out  = E_mdu_out;
        r_kill = mdu_kill;
        r_err  = mdu_err;
        fin    = 1;
      end
      mdu_done = (s >= 0) && (lat > 0) && (c == s + lat - 1) && !fin;
    end
    @(negedge clk);
    E_valid  = 1'b0;
    mdu_done = 1'b0;
  endtask

  logic [31:0] prev_out;

  initial begin
    vecs[0] = '{"mul_7x6",     3'b000, 32'd7,        32'd6,        32'd42,        3, 1, 4, 32'd42};
    vecs[1] = '{"divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,        5, 1, 6, 32'd14};
    vecs[2] = '{"div_by0",     3'b100, 32'd5,        32'd0,        32'h1234,      3, 0, 1, 32'hFFFF_FFFF};
    vecs[3] = '{"remu_by0",    3'b111, 32'd5,        32'd0,        32'h1234,      3, 0, 1, 32'd5};
    vecs[4] = '{"divu_by0",    3'b101, 32'd9,        32'd0,        32'h1234,      3, 0, 1, 32'hFFFF_FFFF};
    vecs[5] = '{"rem_by0",     3'b110, 32'hDEAD_BEEF,32'd0,        32'h1234,      3, 0, 1, 32'hDEAD_BEEF};
    vecs[6] = '{"div_ovf",     3'b100, 32'h8000_0000,32'hFFFF_FFFF,32'h1234,      3, 0, 1, 32'h8000_0000};
    vecs[7] = '{"rem_ovf",     3'b110, 32'h8000_0000,32'hFFFF_FFFF,32'h1234,      3, 0, 1, 32'd0};
    vecs[8] = '{"divu_nonovf", 3'b101, 32'h8000_0000,32'hFFFF_FFFF,32'd0,         2, 1, 3, 32'd0};
    vecs[9] = '{"mulh_lat1",   3'b001, 32'h4000_0000,32'd8,        32'd2,         1, 1, 2, 32'd2};

    rst_n = 1'b0; E_valid = 1'b0; E_op = '0; E_funct3 = '0; E_funct7 = '0;
    E_rs1 = '0; E_rs2 = '0; E_flush = 1'b0; mdu_done = 1'b0; mdu_result = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_start", {31'd0, mdu_start}, 32'd0);
    check("rst_stall", {31'd0, E_mdu_stall}, 32'd0);
    check("rst_out", E_mdu_out, 32'd0);
    check("rst_err", {31'd0, mdu_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Non-M op and M op under flush must not stall or launch.
    @(negedge clk);
    set_m(3'b000, 32'd1, 32'd2);
    E_funct7 = 7'b0000000;
    #1;
    check("nonm_stall", {31'd0, E_mdu_stall}, 32'd0);
    @(negedge clk);
    #1;
    check("nonm_start", {31'd0, mdu_start}, 32'd0);
    E_funct7 = 7'b0000001;
    E_flush  = 1'b1;
    #1;
    check("idle_flush_stall", {31'd0, E_mdu_stall}, 32'd0);
    @(negedge clk);
    #1;
    check("idle_flush_start", {31'd0, mdu_start}, 32'd0);
    E_flush = 1'b0; E_valid = 1'b0;

    // Table of ops, issued back to back.
    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
      check({vecs[i].name, "_start"}, r_start, vecs[i].exp_start);
      check({vecs[i].name, "_stall"}, r_stall, vecs[i].exp_stall);
      check({vecs[i].name, "_valid"}, r_valid, 1);
      check({vecs[i].name, "_out"}, r_out, vecs[i].exp_out);
      if (vecs[i].exp_start != 0) check({vecs[i].name, "_latch"}, {31'd0, r_ab_bad}, 32'd0);
    end
    check("err_clear", {31'd0, mdu_err}, 32'd0);
    prev_out = E_mdu_out;
    check("out_holds", prev_out, 32'd2);

    // Flush two cycles into BUSY, then a late done that must be ignored.
    @(negedge clk);
    set_m(3'b000, 32'd3, 32'd4);
    @(negedge clk); #1;
    check("fl_start", {31'd0, mdu_start}, 32'd1);
    @(negedge clk);
    E_flush = 1'b1;
    #1;
    check("fl_valid_busy", {31'd0, E_mdu_valid}, 32'd0);
    @(negedge clk);
    E_flush = 1'b0; E_valid = 1'b0;
    #1;
    check("fl_kill", {31'd0, mdu_kill}, 32'd1);
    check("fl_stall", {31'd0, E_mdu_stall}, 32'd0);
    check("fl_valid", {31'd0, E_mdu_valid}, 32'd0);
    @(negedge clk);
    mdu_done = 1'b1; mdu_result = 32'd99;
    #1;
    check("fl_kill_pulse", {31'd0, mdu_kill}, 32'd0);
    @(negedge clk);
    mdu_done = 1'b0;
    #1;
    check("late_done_valid", {31'd0, E_mdu_valid}, 32'd0);
    check("late_done_out", E_mdu_out, prev_out);
    check("late_done_stall", {31'd0, E_mdu_stall}, 32'd0);

    // Flush in DONE suppresses valid.
    @(negedge clk);
    set_m(3'b100, 32'd5, 32'd0);
    @(negedge clk);
    E_flush = 1'b1;
    #1;
    check("done_flush_valid", {31'd0, E_mdu_valid}, 32'd0);
    check("done_flush_stall", {31'd0, E_mdu_stall}, 32'd0);
    @(negedge clk);
    E_flush = 1'b0; E_valid = 1'b0;

    // Watchdog: no done ever arrives.
    run_op(3'b000, 32'd11, 32'd13, 32'd143, 0);
    check("wd_start", r_start, 1);
    check("wd_stall", r_stall, 65);
    check("wd_valid", r_valid, 1);
    check("wd_out", r_out, 32'd0);
    check("wd_kill", {31'd0, r_kill}, 32'd1);
    check("wd_err", {31'd0, r_err}, 32'd1);
    run_op(3'b111, 32'd5, 32'd0, 32'd0, 3);
    check("wd_err_sticky", {31'd0, mdu_err}, 32'd1);

    // Reset in the middle of BUSY.
    @(negedge clk);
    set_m(3'b000, 32'd21, 32'd2);
    repeat (3) @(negedge clk);
    E_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, E_mdu_stall}, 32'd0);
    check("mid_rst_start", {31'd0, mdu_start}, 32'd0);
    check("mid_rst_err", {31'd0, mdu_err}, 32'd0);
    check("mid_rst_out", E_mdu_out, 32'd0);
    check("mid_rst_a", mdu_a, 32'd0);
    check("mid_rst_b", mdu_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b000, 32'd7, 32'd6, 32'd42, 3);
    check("post_rst_start", r_start, 1);
    check("post_rst_stall", r_stall, 4);
    check("post_rst_out", r_out, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
